// File: rtl/uart_bcd_transmitter_if.sv
// Handshake and data bundle for the BCD UART transmitter: trigger, flat digit bus,
// serial line and status flags.
interface uart_bcd_transmitter_if #(
    parameter int unsigned NUM_BYTES = 4
);
    logic                     transmit_trig;
    logic [8*NUM_BYTES-1:0]   digits;
    logic                     uart_transmit;
    logic                     busy;
    logic                     done;

    modport master (
        output transmit_trig,
        output digits,
        input  uart_transmit,
        input  busy,
        input  done
    );

    modport slave (
        input  transmit_trig,
        input  digits,
        output uart_transmit,
        output busy,
        output done
    );
endinterface

// File: rtl/uart_bcd_transmitter.sv
// Snapshots 2*NUM_BYTES BCD digits on a trigger edge and sends them as UART bytes, two digits
// per byte, most significant pair first. Define UART_PARITY_EN to add an even-parity bit.
module uart_bcd_transmitter #(
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter int unsigned NUM_BYTES    = 4,
    parameter int unsigned GAP_BITS     = 1
) (
    input  logic                  iclk,
    input  logic                  transmit_reset,
    uart_bcd_transmitter_if.slave bus
);

    localparam int unsigned CntW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned ByteW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int unsigned GapW  = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_PARITY_EN
        StParity,
`endif
        StStop,
        StGap
    } state_e;

    state_e                 state_q, state_d;
    logic                   trig_q, trig_d;
    logic                   line_q, line_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [8*NUM_BYTES-1:0] shadow_q, shadow_d;
    logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [ByteW-1:0]       byte_idx_q, byte_idx_d;
    logic [GapW-1:0]        gap_cnt_q, gap_cnt_d;

    logic [7:0] cur_byte;
    logic       tick;
    logic       last_byte;

    // Byte 0 is the top two digits, so walk the shadow register from the MSB end.
    assign cur_byte  = 8'(shadow_q >> (8 * (NUM_BYTES - 1 - 32'(byte_idx_q))));
    assign tick      = (32'(bit_cnt_q) == CLKS_PER_BIT - 1);
    assign last_byte = (32'(byte_idx_q) == NUM_BYTES - 1);

    always_comb begin
        state_d    = state_q;
        trig_d     = bus.transmit_trig;
        line_d     = line_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        shadow_d   = shadow_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        gap_cnt_d  = gap_cnt_q;
        bit_cnt_d  = (state_q == StIdle || tick) ? '0 : bit_cnt_q + 1'b1;

        case (state_q)
            StIdle: begin
                if (bus.transmit_trig && !trig_q) begin
                    shadow_d   = bus.digits;
                    state_d    = StStart;
                    line_d     = 1'b0;
                    busy_d     = 1'b1;
                    byte_idx_d = '0;
                    bit_idx_d  = '0;
                end
            end
            StStart: begin
                if (tick) begin
                    state_d   = StData;
                    bit_idx_d = '0;
                    line_d    = cur_byte[0];
                end
            end
            StData: begin
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = StParity;
                        line_d  = ^cur_byte;
`else
                        state_d = StStop;
                        line_d  = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        line_d    = cur_byte[bit_idx_q + 3'd1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            StParity: begin
                if (tick) begin
                    state_d = StStop;
                    line_d  = 1'b1;
                end
            end
`endif
            StStop: begin
                if (tick) begin
                    if (last_byte) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (GAP_BITS == 0) begin
                        state_d    = StStart;
                        line_d     = 1'b0;
                        byte_idx_d = byte_idx_q + 1'b1;
                    end else begin
                        state_d   = StGap;
                        gap_cnt_d = '0;
                    end
                end
            end
            StGap: begin
                if (tick) begin
                    if (32'(gap_cnt_q) == GAP_BITS - 1) begin
                        state_d    = StStart;
                        line_d     = 1'b0;
                        byte_idx_d = byte_idx_q + 1'b1;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line is a registered output, so an asynchronous reset lifts it high immediately.
    always_ff @(posedge iclk or posedge transmit_reset) begin
        if (transmit_reset) begin
            state_q    <= StIdle;
            trig_q     <= 1'b0;
            line_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            shadow_q   <= '0;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            trig_q     <= trig_d;
            line_q     <= line_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            shadow_q   <= shadow_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign bus.uart_transmit = line_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;

endmodule

// File: tb/tb_uart_bcd_transmitter.sv
// Bench for uart_bcd_transmitter: expected line waveform built from the frame rules, plus a
// behavioural UART receiver that decodes the captured line back into digits.
module tb_uart_bcd_transmitter;

    localparam int CPB = 10;
    localparam int NB  = 4;
    localparam int GAP = 1;
`ifdef UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int L = NB * FB * CPB + (NB - 1) * GAP * CPB;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_bcd_transmitter_if #(.NUM_BYTES(NB)) bus ();

    uart_bcd_transmitter #(
        .CLKS_PER_BIT(CPB),
        .NUM_BYTES   (NB),
        .GAP_BITS    (GAP)
    ) dut (
        .iclk          (clk),
        .transmit_reset(rst),
        .bus           (bus)
    );

    int total = 0;
    int bad   = 0;
    bit wave[$];
    bit seen[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One UART frame per byte, bytes taken two digits at a time from the top.
    function automatic void build_wave(input logic [8*NB-1:0] d);
        logic [7:0] b;
        bit bits[$];
        wave.delete();
        for (int j = 0; j < NB; j++) begin
            b = d[8*(NB-1-j) +: 8];
            bits.delete();
            bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_PARITY_EN
            bits.push_back(^b);
`endif
            bits.push_back(1'b1);
            foreach (bits[i]) for (int c = 0; c < CPB; c++) wave.push_back(bits[i]);
            if (j < NB - 1) for (int c = 0; c < GAP * CPB; c++) wave.push_back(1'b1);
        end
    endfunction

    // Receiver: hunt for a low, then sample each bit at its centre.
    function automatic void decode(output int n, output logic [8*NB-1:0] v, output int ferr);
        int i;
        logic [7:0] b;
        i = 0; n = 0; v = '0; ferr = 0;
        while (i + FB * CPB <= seen.size()) begin
            if (seen[i] == 1'b0) begin
                for (int k = 0; k < 8; k++) b[k] = seen[i + CPB/2 + CPB*(k+1)];
`ifdef UART_PARITY_EN
                if (seen[i + CPB/2 + 9*CPB] != ^b) ferr++;
`endif
                if (seen[i + CPB/2 + (FB-1)*CPB] != 1'b1) ferr++;
                if (n < NB) v[8*(NB-1-n) +: 8] = b;
                n++;
                i += FB * CPB;
            end else begin
                i++;
            end
        end
    endfunction

    // mode 0: normal trig pulse; 1: trig held high; 2: mid-frame pulse plus digit change.
    task automatic run_frame(input string tag, input logic [8*NB-1:0] d, input int mode,
                             input bit armed, input bit chain, input logic [8*NB-1:0] next_d);
        int wmis, bmis, dmis, n, ferr, imis, extra;
        logic [8*NB-1:0] got;
        build_wave(d);
        seen.delete();
        wmis = 0; bmis = 0; dmis = 0;
        if (!armed) begin
            @(negedge clk);
            bus.digits        = d;
            bus.transmit_trig = 1'b1;
        end
        for (int k = 0; k <= L; k++) begin
            @(negedge clk);
            seen.push_back(bus.uart_transmit);
            if (k < L) begin
                if (bus.uart_transmit !== wave[k]) wmis++;
                if (bus.busy !== 1'b1) bmis++;
                if (bus.done !== 1'b0) dmis++;
            end else begin
                if (bus.busy !== 1'b0) bmis++;
                if (bus.done !== 1'b1) dmis++;
            end
            if (k == 0 && mode != 1) bus.transmit_trig = 1'b0;
            if (mode == 2 && k == 50) begin
                bus.transmit_trig = 1'b1;
                bus.digits        = '0;
            end
            if (mode == 2 && k == 52) bus.transmit_trig = 1'b0;
            if (k == L && chain) begin
                bus.digits        = next_d;
                bus.transmit_trig = 1'b1;
            end
        end
        check($sformatf("%s_wave_mismatches", tag), wmis, 0);
        check($sformatf("%s_busy_mismatches", tag), bmis, 0);
        check($sformatf("%s_done_mismatches", tag), dmis, 0);
        decode(n, got, ferr);
        check($sformatf("%s_rx_bytes", tag), n, NB);
        check($sformatf("%s_rx_digits", tag), got, d);
        check($sformatf("%s_rx_frame_errors", tag), ferr, 0);
        if (!chain) begin
            extra = (mode == 1) ? 1000 - L : 20;
            imis  = 0;
            for (int k = 0; k < extra; k++) begin
                @(negedge clk);
                if (bus.uart_transmit !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) imis++;
            end
            bus.transmit_trig = 1'b0;
            check($sformatf("%s_idle_after", tag), imis, 0);
        end
    endtask

    initial begin
        int mis;
        logic [8*NB-1:0] d1, d2;
        rst               = 1'b1;
        bus.transmit_trig = 1'b0;
        bus.digits        = '0;

        mis = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.uart_transmit !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) mis++;
        end
        check("reset_outputs", mis, 0);
        rst = 1'b0;
        mis = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.uart_transmit !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) mis++;
        end
        check("idle_no_trig", mis, 0);

        run_frame("basic", 32'h12345678, 0, 1'b0, 1'b0, '0);
        run_frame("loopback", 32'h90427713, 0, 1'b0, 1'b0, '0);
        run_frame("parity_mix", 32'h37123712, 0, 1'b0, 1'b0, '0);
        for (int r = 0; r < 3; r++) run_frame("random", $urandom, 0, 1'b0, 1'b0, '0);
        run_frame("hold_high", $urandom, 1, 1'b0, 1'b0, '0);
        run_frame("snapshot", 32'h55AA09F0, 2, 1'b0, 1'b0, '0);

        d1 = $urandom;
        d2 = $urandom;
        run_frame("chain_first", d1, 0, 1'b0, 1'b1, d2);
        run_frame("chain_second", d2, 0, 1'b1, 1'b0, '0);

        // Abort during the data bits of byte 1.
        @(negedge clk);
        bus.digits        = $urandom;
        bus.transmit_trig = 1'b1;
        for (int k = 0; k <= 135; k++) begin
            @(negedge clk);
            if (k == 0) bus.transmit_trig = 1'b0;
        end
        check("rst_mid_busy_before", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_mid_line_async", bus.uart_transmit, 1'b1);
        check("rst_mid_busy_async", bus.busy, 1'b0);
        mis = 0;
        for (int k = 0; k < 33; k++) begin
            @(negedge clk);
            if (k == 2) rst = 1'b0;
            if (bus.uart_transmit !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) mis++;
        end
        check("rst_mid_no_done", mis, 0);
        run_frame("after_reset", $urandom, 0, 1'b0, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
